// File: rtl/axo_scoreboard_pkg.sv
// Shared constants and helpers for the Axolotl register scoreboard.
// Latency: none (package only).
// Backpressure: not applicable.
package axo_scoreboard_pkg;

    localparam int AXO_REG_W    = 5;
    localparam int AXO_NUM_REGS = 32;

    // One-hot select over x1..x31; x0 never maps to a pending bit.
    function automatic logic [31:1] axo_reg_bit(input logic [AXO_REG_W-1:0] idx);
        logic [31:1] b;
        for (int i = 1; i < AXO_NUM_REGS; i++) begin
            b[i] = (idx == AXO_REG_W'(i));
        end
        return b;
    endfunction

endpackage

// File: rtl/axo_defines.sv
// Shared macros for the Axolotl pipeline blocks.
// Latency: none (preprocessor only).
// Backpressure: not applicable.
`ifndef AXO_DEFINES_SV
`define AXO_DEFINES_SV

// Width of a counter that must hold the values 0..n inclusive.
`define AXO_SB_CNT_W(n) ($clog2((n) + 1))

// Protocol check: reports but never alters behaviour.
`define AXO_ASSERT(cond, msg) assert (cond) else $error(msg);

`endif

// File: rtl/axo_wb_arbiter.sv
// Register-file write-port mux: single-cycle ALU writeback over long-latency writeback.
// Latency: purely combinational, zero cycles.
// Backpressure: lsu_ready drops whenever the ALU writes; LSU must hold its offer.
// Ports: rst, ALU write (alu_we/rd/data), LSU offer (lsu_valid/rd/data) -> lsu_ready,
//        lsu_accept strobe, regfile write port rf_we/rf_rd/rf_din.
module axo_wb_arbiter
    import axo_scoreboard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 rst,
    input  logic                 alu_we,
    input  logic [AXO_REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 lsu_valid,
    input  logic [AXO_REG_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 lsu_ready,
    output logic                 lsu_accept,
    output logic                 rf_we,
    output logic [AXO_REG_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_din
);

    assign lsu_ready  = !rst && !alu_we;
    assign lsu_accept = lsu_valid && lsu_ready;

    always_comb begin
        rf_we  = 1'b0;
        rf_rd  = '0;
        rf_din = '0;
        if (!rst) begin
            if (alu_we) begin
                rf_we  = (alu_rd != '0);
                rf_rd  = alu_rd;
                rf_din = alu_data;
            end else if (lsu_valid) begin
                rf_we  = (lsu_rd != '0);
                rf_rd  = lsu_rd;
                rf_din = lsu_data;
            end
        end
    end

endmodule

// File: rtl/axo_scoreboard.sv
// Register-hazard scoreboard: stalls issue on RAW/WAW against outstanding long ops, counts them.
// Latency: all outputs combinational from registered state; pending clears at the accept edge.
// Backpressure: issue_ready low on hazard or when MAX_PENDING long ops are outstanding.
// Ports: clk/rst, issue_* from decode, alu_* single-cycle writeback, lsu_* long writeback,
//        rf_* to axo_regfile, busy while any long op is outstanding.
`include "axo_defines.sv"

module axo_scoreboard
    import axo_scoreboard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_PENDING = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [AXO_REG_W-1:0] issue_rs1,
    input  logic [AXO_REG_W-1:0] issue_rs2,
    input  logic [AXO_REG_W-1:0] issue_rd,
    input  logic                 issue_has_rs1,
    input  logic                 issue_has_rs2,
    input  logic                 issue_has_rd,
    input  logic                 issue_long,
    input  logic                 alu_we,
    input  logic [AXO_REG_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [AXO_REG_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 rf_we,
    output logic [AXO_REG_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_din,
    output logic                 busy
);

    localparam int CNT_W = `AXO_SB_CNT_W(MAX_PENDING);

    logic [31:1]      pending;
    logic [31:1]      pending_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // x0 slot is tied to zero so register indices can be used directly.
    logic [31:0] pend_vec;
    assign pend_vec = {pending, 1'b0};

    logic raw1, raw2, waw, full;
    logic issue_fire, lsu_accept;
    logic cnt_inc, cnt_dec;
    logic [31:1] set_vec, clr_vec;

    // Hazards look only at registered state: a result accepted this cycle
    // unblocks its consumer in the following cycle.
    assign raw1 = issue_has_rs1 && pend_vec[issue_rs1];
    assign raw2 = issue_has_rs2 && pend_vec[issue_rs2];
    assign waw  = issue_has_rd  && pend_vec[issue_rd];
    assign full = issue_long && (count == CNT_W'(MAX_PENDING));

    assign issue_ready = !rst && !raw1 && !raw2 && !waw && !full;
    assign issue_fire  = issue_valid && issue_ready;
    assign busy        = !rst && (count != '0);

    axo_wb_arbiter #(.XLEN(XLEN)) u_wb_arb (
        .rst        (rst),
        .alu_we     (alu_we),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .lsu_ready  (lsu_ready),
        .lsu_accept (lsu_accept),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_din     (rf_din)
    );

    // A spurious accept with nothing outstanding leaves count at zero.
    assign cnt_inc = issue_fire && issue_long;
    assign cnt_dec = lsu_accept && (count != '0);

    // axo_reg_bit never selects x0, so rd=0 long ops only touch the count.
    assign set_vec = (cnt_inc && issue_has_rd) ? axo_reg_bit(issue_rd) : '0;
    assign clr_vec = lsu_accept ? axo_reg_bit(lsu_rd) : '0;

    // WAW stall guarantees set and clear never target the same register.
    assign pending_nxt = (pending & ~clr_vec) | set_vec;

    always_comb begin
        count_nxt = count;
        unique case ({cnt_inc, cnt_dec})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pending_nxt;
            count   <= count_nxt;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            `AXO_ASSERT(!(lsu_accept && count == '0), "axo_scoreboard: LSU accept with no outstanding op")
            `AXO_ASSERT(!(alu_we && pend_vec[alu_rd]), "axo_scoreboard: ALU write to a pending register")
        end
    end

endmodule

// File: tb/tb_axo_scoreboard.sv
module tb_axo_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_has_rs1, issue_has_rs2, issue_has_rd, issue_long;
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_din;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axo_scoreboard #(.XLEN(32), .MAX_PENDING(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_has_rs1 (issue_has_rs1),
        .issue_has_rs2 (issue_has_rs2),
        .issue_has_rd  (issue_has_rd),
        .issue_long    (issue_long),
        .alu_we        (alu_we),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .rf_we         (rf_we),
        .rf_rd         (rf_rd),
        .rf_din        (rf_din),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it, checks follow at +2.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_has_rs1 = 0; issue_has_rs2 = 0; issue_has_rd = 0; issue_long = 0;
        alu_we = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic put_issue(input logic lng, input logic [4:0] rd, input logic has_rd);
        issue_valid = 1; issue_long = lng; issue_rd = rd; issue_has_rd = has_rd;
        issue_has_rs1 = 0; issue_has_rs2 = 0; issue_rs1 = 0; issue_rs2 = 0;
    endtask

    task automatic put_lsu(input logic [4:0] rd, input logic [31:0] data);
        lsu_valid = 1; lsu_rd = rd; lsu_data = data;
    endtask

    initial begin
        idle();
        rst = 1;
        // Reset: outputs forced low even with demands present
        issue_valid = 1; lsu_valid = 1; lsu_rd = 4; alu_we = 0;
        settle();
        chk("rst_issue_ready", 32'(issue_ready), 0);
        chk("rst_lsu_ready",   32'(lsu_ready),   0);
        chk("rst_rf_we",       32'(rf_we),       0);
        chk("rst_busy",        32'(busy),        0);
        step();
        idle(); rst = 0;
        settle();
        chk("post_rst_count",   32'(dut.count),   0);
        chk("post_rst_pending", 32'(dut.pending), 0);
        chk("post_rst_ready",   32'(issue_ready), 1);

        // RAW: long to x5, then add x6,x5,x1
        put_issue(1, 5, 1);
        settle();
        chk("raw_long_ready", 32'(issue_ready), 1);
        step();
        issue_valid = 1; issue_long = 0; issue_rd = 6; issue_has_rd = 1;
        issue_rs1 = 5; issue_has_rs1 = 1; issue_rs2 = 1; issue_has_rs2 = 1;
        settle();
        chk("raw_pend5", 32'(dut.pending[5]), 1);
        chk("raw_busy",  32'(busy), 1);
        chk("raw_stall", 32'(issue_ready), 0);
        step();
        chk("raw_stall2", 32'(issue_ready), 0);
        put_lsu(5, 32'hAB);
        settle();
        chk("raw_acc_lsu_ready", 32'(lsu_ready), 1);
        chk("raw_acc_rf_we",     32'(rf_we), 1);
        chk("raw_acc_rf_rd",     32'(rf_rd), 5);
        chk("raw_acc_rf_din",    rf_din, 32'hAB);
        chk("raw_acc_no_bypass", 32'(issue_ready), 0);
        step();
        lsu_valid = 0;
        settle();
        chk("raw_add_ready", 32'(issue_ready), 1);
        chk("raw_pend5_clr", 32'(dut.pending[5]), 0);
        chk("raw_busy_clr",  32'(busy), 0);
        step();
        idle();
        settle();
        chk("raw_count0", 32'(dut.count), 0);

        // Full: three long ops to x1..x3, fourth to x4 stalls
        for (int r = 1; r <= 3; r++) begin
            put_issue(1, 5'(r), 1);
            step();
        end
        put_issue(1, 4, 1);
        settle();
        chk("full_count3", 32'(dut.count), 3);
        chk("full_stall",  32'(issue_ready), 0);
        chk("full_busy",   32'(busy), 1);
        put_lsu(1, 32'h1);
        step();
        lsu_valid = 0;
        settle();
        chk("full_count2",  32'(dut.count), 2);
        chk("full_4_ready", 32'(issue_ready), 1);
        step();
        idle();
        settle();
        chk("full_count_back3", 32'(dut.count), 3);
        chk("full_pending", 32'(dut.pending), 32'h0000_000E);
        for (int r = 2; r <= 4; r++) begin
            put_lsu(5'(r), 32'(r));
            step();
        end
        idle();
        settle();
        chk("full_drained", 32'(dut.count), 0);

        // Arbitration: ALU wins, LSU goes next cycle
        put_issue(1, 8, 1);
        step();
        idle();
        alu_we = 1; alu_rd = 7; alu_data = 32'h11;
        put_lsu(8, 32'h22);
        settle();
        chk("arb_alu_rd",    32'(rf_rd), 7);
        chk("arb_alu_din",   rf_din, 32'h11);
        chk("arb_alu_we",    32'(rf_we), 1);
        chk("arb_lsu_block", 32'(lsu_ready), 0);
        step();
        alu_we = 0;
        settle();
        chk("arb_lsu_rd",    32'(rf_rd), 8);
        chk("arb_lsu_din",   rf_din, 32'h22);
        chk("arb_lsu_ready", 32'(lsu_ready), 1);
        step();
        idle();
        settle();
        chk("arb_count0", 32'(dut.count), 0);

        // Long op to x0: counted, no pending bit, no regfile write
        put_issue(1, 0, 1);
        step();
        idle();
        settle();
        chk("x0_count1",  32'(dut.count), 1);
        chk("x0_pending", 32'(dut.pending), 0);
        put_lsu(0, 32'h55);
        settle();
        chk("x0_rf_we", 32'(rf_we), 0);
        step();
        idle();
        settle();
        chk("x0_count0", 32'(dut.count), 0);

        // Simultaneous long issue (x9) and accept (x3)
        put_issue(1, 3, 1);
        step();
        put_issue(1, 9, 1);
        put_lsu(3, 32'h33);
        step();
        idle();
        settle();
        chk("sim_count1", 32'(dut.count), 1);
        chk("sim_pend9",  32'(dut.pending[9]), 1);
        chk("sim_pend3",  32'(dut.pending[3]), 0);
        put_issue(0, 9, 1);
        settle();
        chk("sim_waw_stall", 32'(issue_ready), 0);

        // Mid-operation reset with two outstanding
        put_issue(1, 10, 1);
        step();
        idle();
        settle();
        chk("mrst_count2", 32'(dut.count), 2);
        rst = 1;
        issue_valid = 1; put_lsu(9, 32'h99);
        settle();
        chk("mrst_issue_ready", 32'(issue_ready), 0);
        chk("mrst_lsu_ready",   32'(lsu_ready), 0);
        chk("mrst_rf_we",       32'(rf_we), 0);
        step();
        idle(); rst = 0;
        settle();
        chk("mrst_count",   32'(dut.count), 0);
        chk("mrst_pending", 32'(dut.pending), 0);
        chk("mrst_busy",    32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axo_scoreboard.md
# axo_scoreboard

Register-hazard scoreboard and register-file write-port scheduler for the Axolotl integer pipeline. It holds back instruction issue until no source or destination register is waiting on a long-latency result (load, multiply/divide) and counts those outstanding operations. It also shares the single `axo_regfile` write port between the single-cycle ALU writeback and the long-latency (LSU/MDU) writeback. It sits between decode (fed by `axo_reg_decoder` outputs) and `axo_regfile`.

## Interface
Parameters:
- `XLEN`, 32: register width.
- `MAX_PENDING`, 3: maximum simultaneously outstanding long-latency operations, from 1 to 15.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `issue_valid`  in  1: decode presents an instruction.
- `issue_ready`  out  1: instruction may issue this cycle.
- `issue_rs1`, `issue_rs2`, `issue_rd`  in  5 each: register indices.
- `issue_has_rs1`, `issue_has_rs2`, `issue_has_rd`  in  1 each: register-presence flags from `axo_reg_decoder`.
- `issue_long`  in  1: the instruction completes through the long writeback port.
- `alu_we`  in  1: single-cycle writeback is valid this cycle.
- `alu_rd`  in  5: single-cycle writeback index.
- `alu_data`  in  XLEN: single-cycle writeback data.
- `lsu_valid`  in  1: long-latency result is offered.
- `lsu_ready`  out  1: long-latency result is accepted this cycle.
- `lsu_rd`  in  5: long-latency writeback index.
- `lsu_data`  in  XLEN: long-latency writeback data.
- `rf_we`  out  1: drives `axo_regfile.we`.
- `rf_rd`  out  5: drives `axo_regfile.rd`.
- `rf_din`  out  XLEN: drives `axo_regfile.din`.
- `busy`  out  1: at least one long-latency operation is outstanding. Used for fence and trap entry.

## Operation
State:
- `pending[31:1]`: one bit per register.
- `count`: `$clog2(MAX_PENDING+1)` bits.
- There is no pending bit for x0.

Hazard check, using registered state only (no bypass):
- `raw1` = `issue_has_rs1 && issue_rs1!=0 && pending[issue_rs1]`.
- `raw2` is the same check for rs2.
- `waw` is the same check for rd, using `issue_has_rd`.
- `full` = `issue_long && count==MAX_PENDING`.
- `issue_ready` = `!rst && !raw1 && !raw2 && !waw && !full`.
- `issue_ready` does not depend on `issue_valid`.

Issue handshake: `issue_valid && issue_ready`.
- If `issue_long`: `count`+1.
- If additionally `issue_has_rd && issue_rd!=0`: set `pending[issue_rd]`.

Write-port arbitration: the ALU has fixed priority.
- `lsu_ready` = `!rst && !alu_we`.
- When `alu_we`: `rf_we`=`alu_rd!=0`, `rf_rd`=`alu_rd`, `rf_din`=`alu_data`.
- When not `alu_we` and `lsu_valid`: `rf_we`=`lsu_rd!=0`, `rf_rd`=`lsu_rd`, `rf_din`=`lsu_data`.
- Otherwise `rf_we`=0, `rf_rd`=0, `rf_din`=0.

LSU accept: `lsu_valid && lsu_ready`.
- `count`-1.
- Clear `pending[lsu_rd]` if `lsu_rd!=0`.

Simultaneous events:
- Long issue and LSU accept in the same cycle: `count` is unchanged. The set of the new rd and the clear of `lsu_rd` both apply.
- The same register cannot be both set and cleared in one cycle, because `waw` blocks issue while `pending[rd]` is set.

Error conditions:
- LSU accept while `count`==0: protocol error. Simulation assertion fires; `count` stays 0.
- `alu_we` with `alu_rd` pending: protocol error. Simulation assertion fires; the write proceeds.

Reset:
- `pending` and `count` are cleared on the first edge with `rst`=1, including mid-operation. In-flight long results are discarded by upstream, which is reset too.
- While `rst`=1: `issue_ready`=0, `lsu_ready`=0, `rf_we`=0, `busy`=0.

## Timing
- All outputs are combinational from registered state and current inputs. No output is registered.
- A write presented on `rf_*` lands in `axo_regfile` at the same edge that clears `pending`. A dependent instruction issues at the earliest in the cycle after the LSU accept (1-cycle RAW turnaround).
- `busy` = `count!=0`, taken from the register, so it falls the cycle after the last accept.
- Starvation: `lsu_valid` must be held until `lsu_ready`. The ALU may block it indefinitely only while ALU writebacks continue back-to-back.

## Structure
- Constant `AXO_SB_CNT_W(n)` and the assertion macros go in `axo_defines.sv`. No new typedefs.
- One sub-module, `axo_wb_arbiter`: the combinational 2:1 priority mux producing `rf_*` and `lsu_ready`, plus an accept strobe.
- `axo_scoreboard` holds the `pending` and `count` registers and the hazard logic. It is 150–250 lines total.

## Test plan
- Long issue with rd=x5, then issue of `add x6,x5,x1`: `issue_ready`=0 until the LSU accept for `lsu_rd`=5; the add issues the next cycle and `pending[5]`=0.
- With MAX_PENDING=3, issue 3 long ops to x1..x3, then a fourth long op to x4: `issue_ready`=0 and `busy`=1. After one accept, the fourth issues and `count` returns to 3.
- `alu_we`=1 (rd=7, data 0x11) and `lsu_valid`=1 (rd=8, data 0x22) in the same cycle: `rf_rd`=7, `lsu_ready`=0. Next cycle with `alu_we`=0: `rf_rd`=8, `rf_din`=0x22.
- Long issue with rd=0: `count`+1 and no pending bit set. Its accept gives `rf_we`=0 and `count`-1.
- Long issue to x9 plus an accept of `lsu_rd`=3 in the same cycle: `count` unchanged, `pending[9]`=1, `pending[3]`=0. A later WAW issue to x9 stalls.
- Assert `rst` with `count`=2: the next cycle has `count`=0, `pending`=0 and `busy`=0. `issue_ready`, `lsu_ready` and `rf_we` are 0 during reset.
